fir_serial_lowpass: RTL and testbench
=====================================

Name: fir_serial_lowpass

Overview:
Serial-MAC FIR low-pass filter for one audio channel. It is the anti-alias stage directly upstream of the channel's filter/bypass mux and downsampler. It takes one 18-bit sample per data_en strobe (48 kHz) and computes the output with one multiply-accumulate per clock. Coefficients are read from the shared coefficient RAM (7-bit address, 8-bit signed data, 1-cycle synchronous read).

Parameters:
NTAPS, 64, number of taps (1..128); NTAPS+4 must not exceed the number of clocks between data_en strobes.
COEF_BASE, 0, RAM address of coefficient h[0]; COEF_BASE+NTAPS-1 <= 127.
COEF_FRAC, 7, fractional bits of coefficients (signed Q0.7, so 127 ≈ 0.992).

Ports:
clock  in  1  master clock
reset  in  1  synchronous, active-high reset
datain  in  18  signed input sample
endata  in  1  input sample strobe, one clock wide
coefaddress  out  7  coefficient RAM read address
coefdata  in  8  signed coefficient; valid one clock after coefaddress
dataout  out  18  signed filtered sample, registered
endataout  out  1  one-clock strobe, dataout is new
busy  out  1  MAC sequence in progress
overrun  out  1  sticky flag: endata arrived while busy

Behaviour:
- Function: y[n] = sat18( ( sum_{k=0..NTAPS-1} h[k]*x[n-k] + 2^(COEF_FRAC-1) ) >>> COEF_FRAC ).
  - h[k] = RAM[COEF_BASE+k]; x[n-k] is the k-th most recent accepted sample.
  - Rounding is half-up.
  - sat18 clamps to [-131072, 131071].
- Widths:
  - Product is 26 bits signed.
  - Accumulator is 26+7 = 33 bits signed and cannot overflow.
  - The shift is arithmetic.
- History buffer: circular, NTAPS x 18 bits, with a write pointer that wraps NTAPS-1 -> 0. Only accepted samples enter it.
- FSM states: IDLE, MAC, DRAIN, OUT.
  - IDLE: busy=0, coefaddress=COEF_BASE. On endata=1 at edge E0: write datain at wptr, clear acc, tap counter k=0, go to MAC.
  - MAC: coefaddress = COEF_BASE+k combinationally from the registered k. The matching history sample is read with the same 1-cycle alignment. Each edge accumulates the product of the previous address's coefficient and sample, then increments k. When k = NTAPS-1 has been issued, go to DRAIN.
  - DRAIN: accumulates the final outstanding product(s) of the 1-cycle RAM pipeline, then go to OUT.
  - OUT: register rounded/saturated result into dataout, pulse endataout, advance wptr, return to IDLE.
- Latency is fixed: dataout/endataout update at edge E(NTAPS+3). endataout is high for exactly one clock. busy is high from after E0 until after E(NTAPS+3).
- dataout holds its value between updates.
- endata while busy (including the OUT cycle): sample dropped, history and current computation unaffected, overrun set to 1. overrun stays set until reset.
- endata in IDLE on the same edge that OUT returns to IDLE is not possible (OUT is still busy) and is treated as overrun.
- Reset, at any time including mid-MAC:
  - dataout=0, endataout=0, busy=0, overrun=0, coefaddress=COEF_BASE.
  - acc=0, wptr=0, k=0, all history entries=0, state=IDLE.
  - Any in-flight result is discarded with no endataout.
- coefaddress only changes in MAC and otherwise rests at COEF_BASE.

Test Plan:
1. Impulse: NTAPS=8, COEF_BASE=0, RAM h[k]=k+1. Drive datain=1000, then seven zeros → dataout sequence 8,16,23,31,39,47,55,63, then 0.
2. DC gain: NTAPS=8, all h=127, constant datain=100 → after 8 samples, steady dataout=794. Repeat with datain=-100 → -794.
3. Saturation: all h=127, NTAPS=8, constant 131071 → 131071; constant -131072 → -131072. No wrap at any step.
4. Timing: single endata at E0 → coefaddress steps 0..7 on consecutive cycles starting the cycle after E0. endataout is a single one-clock pulse at E11, and busy is high exactly in that window.
5. Overrun: second endata 3 clocks after first → overrun=1 and stays set. First output is identical to the no-overrun case. Dropped sample never appears in later outputs.
6. Reset mid-MAC: assert reset at E4 of a sequence → no endataout, dataout=0, overrun=0. Next impulse 1000 with test-1 coefficients reproduces test-1 outputs exactly, so history was cleared.

Source files
------------

// File: rtl/fir_serial_lowpass_if.sv
// Sample, coefficient-RAM and status signals between the serial FIR and its surroundings.
// The slave side is the filter; the master side is the sample source, coefficient RAM and consumer.
interface fir_serial_lowpass_if;
    logic signed [17:0] datain;
    logic               endata;
    logic        [6:0]  coefaddress;
    logic signed [7:0]  coefdata;
    logic signed [17:0] dataout;
    logic               endataout;
    logic               busy;
    logic               overrun;

    modport master (
        output datain, endata, coefdata,
        input  coefaddress, dataout, endataout, busy, overrun
    );

    modport slave (
        input  datain, endata, coefdata,
        output coefaddress, dataout, endataout, busy, overrun
    );
endinterface

// File: rtl/fir_serial_lowpass.sv
// Serial-MAC FIR low-pass: one multiply-accumulate per clock over an NTAPS-deep circular history.
// Coefficients come from a shared RAM with one cycle of read latency.
module fir_serial_lowpass #(
    parameter int NTAPS     = 64,
    parameter int COEF_BASE = 0,
    parameter int COEF_FRAC = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    fir_serial_lowpass_if.slave  bus
);
    localparam int DATA_W = 18;
    localparam int COEF_W = 8;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + 7;
    localparam int PTR_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int RND    = (COEF_FRAC > 0) ? (2 ** (COEF_FRAC - 1)) : 0;

    localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(RND);
    localparam logic signed [ACC_W-1:0] MAX_C = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] MIN_C = -ACC_W'(131072);
    localparam logic        [6:0]       BASE  = 7'(COEF_BASE);
    localparam logic        [PTR_W-1:0] LAST  = PTR_W'(NTAPS - 1);
    localparam logic        [PTR_W:0]   NT_C  = (PTR_W + 1)'(NTAPS);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t                   state, state_nxt;
    logic [PTR_W-1:0]         wptr, k, rd_ptr;
    logic [PTR_W:0]           rd_wrap;
    logic signed [DATA_W-1:0] hist [NTAPS];
    logic signed [DATA_W-1:0] smp_p1;
    logic signed [PROD_W-1:0] prod_p2;
    logic signed [ACC_W-1:0]  acc;
    logic                     vld_p1, vld_p2;

    function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
        return (a + RND_C) >>> COEF_FRAC;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat18(input logic signed [ACC_W-1:0] v);
        if (v > MAX_C)      return MAX_C[DATA_W-1:0];
        else if (v < MIN_C) return MIN_C[DATA_W-1:0];
        else                return v[DATA_W-1:0];
    endfunction

    // Tap k pairs with the k-th most recent sample, walking backwards around the ring.
    assign rd_wrap = {1'b0, wptr} + NT_C - {1'b0, k};
    assign rd_ptr  = (wptr >= k) ? (wptr - k) : rd_wrap[PTR_W-1:0];

    assign bus.busy        = (state != IDLE);
    assign bus.coefaddress = (state == MAC) ? (BASE + 7'(k)) : BASE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.endata) state_nxt = MAC;
            MAC:     if (k == LAST)  state_nxt = DRAIN;
            DRAIN:   if (!vld_p1)    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wptr          <= '0;
            k             <= '0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            smp_p1        <= '0;
            prod_p2       <= '0;
            acc           <= '0;
            bus.dataout   <= '0;
            bus.endataout <= 1'b0;
            bus.overrun   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
        end else begin
            state         <= state_nxt;
            bus.endataout <= 1'b0;
            if (bus.endata && state != IDLE) bus.overrun <= 1'b1;

            // p1: coefficient RAM and history read land together
            vld_p1 <= (state == MAC);
            smp_p1 <= hist[rd_ptr];

            // p2: registered product
            vld_p2  <= vld_p1;
            prod_p2 <= PROD_W'(bus.coefdata) * PROD_W'(smp_p1);

            if (state == IDLE && bus.endata) begin
                hist[wptr] <= bus.datain;
                acc        <= '0;
                k          <= '0;
            end else if (vld_p2) begin
                acc <= acc + ACC_W'(prod_p2);
            end

            if (state == MAC) k <= k + 1'b1;

            if (state == OUT) begin
                bus.dataout   <= sat18(round_half_up(acc));
                bus.endataout <= 1'b1;
                wptr          <= (wptr == LAST) ? '0 : (wptr + 1'b1);
            end
        end
    end
endmodule

// File: tb/tb_fir_serial_lowpass.sv
// Bench for fir_serial_lowpass with NTAPS=8: vector tables, a reference model and an output scoreboard.
module tb_fir_serial_lowpass;
    localparam int NT = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fir_serial_lowpass_if bus();

    fir_serial_lowpass #(.NTAPS(NT), .COEF_BASE(0), .COEF_FRAC(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Coefficient RAM with one cycle of read latency.
    logic signed [7:0] ram [128];
    always @(posedge clock) bus.coefdata <= ram[bus.coefaddress];

    typedef struct {
        logic signed [17:0] din;
        logic signed [17:0] exp;
    } vec_t;

    vec_t               imp [9];
    int                 compared   = 0;
    int                 mismatched = 0;
    logic signed [17:0] expq [$];
    logic signed [17:0] mh [NT];

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NT; i++) mh[i] = '0;
    endtask

    // Direct-form reference: y = sat(round(sum h[k]*x[n-k] / 128)).
    task automatic model_push(input logic signed [17:0] x, output logic signed [17:0] y);
        longint s;
        for (int i = NT - 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = x;
        s = 0;
        for (int i = 0; i < NT; i++) s += longint'(ram[i]) * longint'(mh[i]);
        s = (s + 64) >>> 7;
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        y = 18'(s);
    endtask

    task automatic set_ram_ramp();
        for (int i = 0; i < 128; i++) ram[i] = (i < NT) ? 8'(i + 1) : 8'sd55;
    endtask

    task automatic set_ram_flat();
        for (int i = 0; i < 128; i++) ram[i] = (i < NT) ? 8'sd127 : -8'sd3;
    endtask

    // Advance to the next falling edge and score any output strobe seen there.
    task automatic tick();
        logic signed [17:0] e;
        @(negedge clock);
        if (bus.endataout) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got %0d, expected no output", bus.dataout);
            end else begin
                e = expq.pop_front();
                check("dataout", bus.dataout, e);
            end
        end
    endtask

    task automatic strobe(input logic signed [17:0] x);
        bus.datain = x;
        bus.endata = 1'b1;
        tick();
        bus.endata = 1'b0;
        bus.datain = '0;
    endtask

    task automatic send(input logic signed [17:0] x, input logic signed [17:0] e);
        expq.push_back(e);
        strobe(x);
        repeat (NT + 5) tick();
    endtask

    task automatic send_model(input logic signed [17:0] x);
        logic signed [17:0] y;
        model_push(x, y);
        send(x, y);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic run_impulse_table();
        logic signed [17:0] y;
        for (int i = 0; i < 9; i++) begin
            model_push(imp[i].din, y);
            send(imp[i].din, imp[i].exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic signed [17:0] y;

        imp[0] = '{18'sd1000, 18'sd8};
        imp[1] = '{18'sd0,    18'sd16};
        imp[2] = '{18'sd0,    18'sd23};
        imp[3] = '{18'sd0,    18'sd31};
        imp[4] = '{18'sd0,    18'sd39};
        imp[5] = '{18'sd0,    18'sd47};
        imp[6] = '{18'sd0,    18'sd55};
        imp[7] = '{18'sd0,    18'sd63};
        imp[8] = '{18'sd0,    18'sd0};

        reset      = 1'b1;
        bus.endata = 1'b0;
        bus.datain = '0;
        set_ram_ramp();
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        tick();

        check("reset_dataout",     bus.dataout,     0);
        check("reset_endataout",   bus.endataout,   0);
        check("reset_busy",        bus.busy,        0);
        check("reset_overrun",     bus.overrun,     0);
        check("reset_coefaddress", bus.coefaddress, 0);

        // Impulse response through the ramp coefficients.
        run_impulse_table();

        // DC gain and saturation with flat coefficients.
        do_reset();
        set_ram_flat();
        repeat (NT) send_model(18'sd100);
        check("dc_pos", bus.dataout, 794);
        repeat (NT) send_model(-18'sd100);
        check("dc_neg", bus.dataout, -794);
        repeat (NT) send_model(18'sd131071);
        check("sat_pos", bus.dataout, 131071);
        repeat (NT) send_model(-18'sd131072);
        check("sat_neg", bus.dataout, -131072);

        // Cycle-by-cycle timing of one computation.
        do_reset();
        set_ram_ramp();
        model_push(18'sd1000, y);
        expq.push_back(y);
        strobe(18'sd1000);
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) tick();
            check($sformatf("coefaddress_E%0d", j), bus.coefaddress, (j <= 7) ? j : 0);
            check($sformatf("busy_E%0d", j),        bus.busy,        (j <= 10) ? 1 : 0);
            check($sformatf("endataout_E%0d", j),   bus.endataout,   (j == 11) ? 1 : 0);
        end
        repeat (3) tick();

        // Overrun: a second strobe three clocks in is dropped.
        do_reset();
        check("overrun_clear", bus.overrun, 0);
        model_push(18'sd1000, y);
        expq.push_back(y);
        strobe(18'sd1000);
        repeat (2) tick();
        strobe(18'sd5000);
        repeat (NT + 3) tick();
        check("overrun_set", bus.overrun, 1);
        repeat (3) send_model(18'sd0);
        check("overrun_sticky", bus.overrun, 1);

        // Reset in the middle of a computation discards it and clears history.
        strobe(18'sd777);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        repeat (NT + 6) tick();
        check("midreset_dataout", bus.dataout, 0);
        check("midreset_overrun", bus.overrun, 0);
        check("midreset_busy",    bus.busy,    0);
        run_impulse_table();

        check("pending_outputs", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
